// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM/grant encodings, default sizes
// and the fetch-versus-data arbitration decision.
package mem_arb_pkg;

  localparam int DATA_SIZE_DEF      = 32;
  localparam int ADDRESS_SIZE_DEF   = 16;
  localparam int MAX_DATA_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // Data wins by default; fetch only wins a collision once the data streak
  // has reached its limit. The caller guarantees at least one request is high.
  function automatic grant_e arbitrate(input logic fetch_pending,
                                       input logic data_pending,
                                       input logic burst_full);
    if (data_pending && !(fetch_pending && burst_full)) begin
      return GRANT_DATA;
    end
    return GRANT_FETCH;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, RAM port and busy flag. The arbiter
// uses the master view; requesters and the RAM model use the slave view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
);

  // Instruction-fetch port
  logic                    if_req;
  logic [ADDRESS_SIZE-1:0] if_addr;
  logic                    if_ack;
  logic [DATA_SIZE-1:0]    if_rdata;

  // Load/store port
  logic                    d_req;
  logic                    d_we;
  logic [ADDRESS_SIZE-1:0] d_addr;
  logic [DATA_SIZE-1:0]    d_wdata;
  logic                    d_ack;
  logic [DATA_SIZE-1:0]    d_rdata;

  // Single-port synchronous RAM
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0]    mem_wdata;
  logic [DATA_SIZE-1:0]    mem_rdata;

  logic                    busy;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction fetch and load/store accesses onto one synchronous
// single-port RAM. Each access takes IDLE -> ISSUE -> RESP; data accesses win
// collisions until MAX_DATA_BURST consecutive data grants have starved fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_SIZE_DEF,
  parameter int ADDRESS_SIZE   = ADDRESS_SIZE_DEF,
  parameter int MAX_DATA_BURST = MAX_DATA_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master arb
);

  localparam int                   STREAK_W   = $clog2(MAX_DATA_BURST + 1);
  localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

  state_e                  state_q, state_d;
  grant_e                  grant_q, grant_d;
  logic                    we_q, we_d;
  logic [STREAK_W-1:0]     streak_q, streak_d;

  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_SIZE-1:0]    mem_wdata_q, mem_wdata_d;
  logic                    if_ack_q, if_ack_d;
  logic                    d_ack_q, d_ack_d;
  logic [DATA_SIZE-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_SIZE-1:0]    d_rdata_q, d_rdata_d;
  logic                    busy_q, busy_d;

  // State register of the access sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant/streak bookkeeping and next values of every output.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    we_d        = we_q;
    streak_d    = streak_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (arb.if_req || arb.d_req) begin
          grant_d = arbitrate(arb.if_req, arb.d_req, streak_q == STREAK_MAX);
          if (grant_d == GRANT_DATA) begin
            we_d        = arb.d_we;
            mem_addr_d  = arb.d_addr;
            mem_wdata_d = arb.d_wdata;
            // Streak only grows while fetch is actually being made to wait.
            if (arb.if_req) begin
              streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
            end else begin
              streak_d = '0;
            end
          end else begin
            we_d       = 1'b0;
            mem_addr_d = arb.if_addr;
            streak_d   = '0;
          end
          // The strobe is registered here so it is high for the whole ISSUE cycle.
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (grant_q == GRANT_FETCH) begin
          if_ack_d = 1'b1;
        end else begin
          d_ack_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (grant_q == GRANT_FETCH) begin
          if_rdata_d = arb.mem_rdata;
        end else if (!we_q) begin
          d_rdata_d = arb.mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Registered datapath and outputs; reset in ISSUE suppresses the coming ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= GRANT_FETCH;
      we_q        <= 1'b0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      we_q        <= we_d;
      streak_q    <= streak_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign arb.mem_en    = mem_en_q;
  assign arb.mem_we    = mem_we_q;
  assign arb.mem_addr  = mem_addr_q;
  assign arb.mem_wdata = mem_wdata_q;
  assign arb.if_ack    = if_ack_q;
  assign arb.d_ack     = d_ack_q;
  assign arb.busy      = busy_q;

  // The RAM's registered read data only arrives in the ack cycle, so during a
  // read ack it is forwarded straight out; the rdata register captures it at
  // the end of that cycle and holds it until the next response.
  assign arb.if_rdata = if_ack_q ? arb.mem_rdata : if_rdata_q;
  assign arb.d_rdata  = (d_ack_q && !we_q) ? arb.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store/load, collision, starvation
// bound, idle hold and reset in ISSUE / RESP, against a behavioural RAM.

// Behavioural single-port RAM: one-cycle read latency, write on en & we.
module sync_ram #(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   check_cnt = 0;
  int   err_cnt = 0;

  mem_arbiter_if #(.DATA_SIZE(32), .ADDRESS_SIZE(16)) bus_if ();

  mem_arbiter #(
    .DATA_SIZE(32),
    .ADDRESS_SIZE(16),
    .MAX_DATA_BURST(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (bus_if)
  );

  sync_ram #(.DW(32), .AW(16)) u_ram (
    .clk  (clk),
    .en   (bus_if.mem_en),
    .we   (bus_if.mem_we),
    .addr (bus_if.mem_addr),
    .wdata(bus_if.mem_wdata),
    .rdata(bus_if.mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_ack"},    32'(bus_if.if_ack),   32'd0);
    check({tag, "_d_ack"},     32'(bus_if.d_ack),    32'd0);
    check({tag, "_mem_en"},    32'(bus_if.mem_en),   32'd0);
    check({tag, "_mem_we"},    32'(bus_if.mem_we),   32'd0);
    check({tag, "_mem_addr"},  32'(bus_if.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus_if.mem_wdata,     32'd0);
    check({tag, "_if_rdata"},  bus_if.if_rdata,      32'd0);
    check({tag, "_d_rdata"},   bus_if.d_rdata,       32'd0);
    check({tag, "_busy"},      32'(bus_if.busy),     32'd0);
  endtask

  // Expected ack order under sustained contention: {if_ack, d_ack}.
  logic [1:0] exp_seq [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                               2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    bus_if.if_req  = 1'b0;
    bus_if.if_addr = '0;
    bus_if.d_req   = 1'b0;
    bus_if.d_we    = 1'b0;
    bus_if.d_addr  = '0;
    bus_if.d_wdata = '0;
    u_ram.mem[4] <= 32'hE3A01005;
    u_ram.mem[5] <= 32'h12345678;

    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("rst_idle_busy", 32'(bus_if.busy), 32'd0);

    // Single fetch from 0x0004
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 16'h0004;
    tick();
    check("fetch_c1_mem_en",   32'(bus_if.mem_en),   32'd1);
    check("fetch_c1_mem_we",   32'(bus_if.mem_we),   32'd0);
    check("fetch_c1_mem_addr", 32'(bus_if.mem_addr), 32'h0004);
    check("fetch_c1_busy",     32'(bus_if.busy),     32'd1);
    tick();
    check("fetch_c2_if_ack",   32'(bus_if.if_ack),   32'd1);
    check("fetch_c2_if_rdata", bus_if.if_rdata,      32'hE3A01005);
    check("fetch_c2_mem_en",   32'(bus_if.mem_en),   32'd0);
    bus_if.if_req = 1'b0;
    tick();
    check("fetch_c3_busy",     32'(bus_if.busy),     32'd0);
    check("fetch_c3_if_ack",   32'(bus_if.if_ack),   32'd0);
    check("fetch_c3_if_rdata", bus_if.if_rdata,      32'hE3A01005);

    // Store 0xDEADBEEF to 0x0100, then load it back
    bus_if.d_req   = 1'b1;
    bus_if.d_we    = 1'b1;
    bus_if.d_addr  = 16'h0100;
    bus_if.d_wdata = 32'hDEADBEEF;
    tick();
    check("st_c1_mem_en",    32'(bus_if.mem_en),   32'd1);
    check("st_c1_mem_we",    32'(bus_if.mem_we),   32'd1);
    check("st_c1_mem_addr",  32'(bus_if.mem_addr), 32'h0100);
    check("st_c1_mem_wdata", bus_if.mem_wdata,     32'hDEADBEEF);
    tick();
    check("st_c2_d_ack",     32'(bus_if.d_ack),    32'd1);
    check("st_c2_d_rdata",   bus_if.d_rdata,       32'd0);
    bus_if.d_we = 1'b0;
    tick();
    check("ld_c0_busy",      32'(bus_if.busy),     32'd0);
    tick();
    check("ld_c1_mem_en",    32'(bus_if.mem_en),   32'd1);
    check("ld_c1_mem_we",    32'(bus_if.mem_we),   32'd0);
    tick();
    check("ld_c2_d_ack",     32'(bus_if.d_ack),    32'd1);
    check("ld_c2_d_rdata",   bus_if.d_rdata,       32'hDEADBEEF);
    check("ld_c2_if_rdata",  bus_if.if_rdata,      32'hE3A01005);
    bus_if.d_req = 1'b0;
    tick();

    // Collision: data read of 0x0100 and fetch of 0x0005 in the same IDLE cycle
    bus_if.d_req   = 1'b1;
    bus_if.d_we    = 1'b0;
    bus_if.d_addr  = 16'h0100;
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 16'h0005;
    tick();
    check("col_c1_mem_addr", 32'(bus_if.mem_addr), 32'h0100);
    tick();
    check("col_c2_acks",     32'({bus_if.if_ack, bus_if.d_ack}), 32'b01);
    check("col_c2_d_rdata",  bus_if.d_rdata,       32'hDEADBEEF);
    bus_if.d_req = 1'b0;
    tick();
    check("col_c3_acks",     32'({bus_if.if_ack, bus_if.d_ack}), 32'b00);
    tick();
    check("col_c4_mem_addr", 32'(bus_if.mem_addr), 32'h0005);
    tick();
    check("col_c5_acks",     32'({bus_if.if_ack, bus_if.d_ack}), 32'b10);
    check("col_c5_if_rdata", bus_if.if_rdata,      32'h12345678);
    bus_if.if_req = 1'b0;
    tick();

    // Starvation bound: both requests held continuously for 10 accesses
    bus_if.d_req   = 1'b1;
    bus_if.d_we    = 1'b0;
    bus_if.d_addr  = 16'h0100;
    bus_if.if_req  = 1'b1;
    bus_if.if_addr = 16'h0004;
    n_ack = 0;
    for (int i = 1; i <= 29; i++) begin
      tick();
      if (bus_if.if_ack || bus_if.d_ack) begin
        if (n_ack < 10) begin
          check($sformatf("starve_ack%0d", n_ack),
                32'({bus_if.if_ack, bus_if.d_ack}), 32'(exp_seq[n_ack]));
        end
        n_ack++;
      end
      if (i == 29) begin
        bus_if.d_req  = 1'b0;
        bus_if.if_req = 1'b0;
      end
    end
    check("starve_ack_count", 32'(n_ack), 32'd10);
    tick();

    // Idle hold: ten quiet cycles, read data registers keep their values
    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle_quiet%0d", i),
            32'({bus_if.mem_en, bus_if.if_ack, bus_if.d_ack}), 32'd0);
      tick();
    end
    check("idle_if_rdata", bus_if.if_rdata, 32'hE3A01005);
    check("idle_d_rdata",  bus_if.d_rdata,  32'hDEADBEEF);

    // Reset during ISSUE of a write to 0x0200
    bus_if.d_req   = 1'b1;
    bus_if.d_we    = 1'b1;
    bus_if.d_addr  = 16'h0200;
    bus_if.d_wdata = 32'hCAFEF00D;
    tick();
    check("rsti_c1_mem_we", 32'(bus_if.mem_we), 32'd1);
    reset        = 1'b1;
    bus_if.d_req = 1'b0;
    tick();
    check_reset_outputs("rsti");
    check("rsti_ram_written", u_ram.mem[16'h0200], 32'hCAFEF00D);
    reset = 1'b0;
    tick();
    check("rsti_no_late_ack", 32'({bus_if.if_ack, bus_if.d_ack}), 32'd0);

    // Read back 0x0200, then reset during the RESP of a read of 0x0100
    bus_if.d_req  = 1'b1;
    bus_if.d_we   = 1'b0;
    bus_if.d_addr = 16'h0200;
    tick();
    tick();
    check("rd200_d_ack",   32'(bus_if.d_ack), 32'd1);
    check("rd200_d_rdata", bus_if.d_rdata,    32'hCAFEF00D);
    bus_if.d_addr = 16'h0100;
    tick();
    tick();
    tick();
    check("rstr_d_ack",   32'(bus_if.d_ack), 32'd1);
    check("rstr_d_rdata", bus_if.d_rdata,    32'hDEADBEEF);
    reset        = 1'b1;
    bus_if.d_req = 1'b0;
    tick();
    check_reset_outputs("rstr");
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
